// File: rtl/mips_mult_div_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mips_mult_div_if
// Description : Bundles the operand, command, handshake and HI/LO result
//               signals of the multiply/divide unit.
//               master : control side (drives operands and commands)
//               slave  : the multiply/divide unit
//               Optional build macro MULDIV_ABORT_EN adds signal_abort.
// Ports       : operand_a, operand_b, op, signal_start, signal_mthi,
//               signal_mtlo, write_data (master->slave);
//               signal_busy, signal_done, hi_out, lo_out (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mult_div_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [1:0]        op;
  logic              signal_start;
  logic              signal_mthi;
  logic              signal_mtlo;
  logic [DATA_W-1:0] write_data;
`ifdef MULDIV_ABORT_EN
  logic              signal_abort;
`endif
  logic              signal_busy;
  logic              signal_done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
`ifdef MULDIV_ABORT_EN
    output signal_abort,
`endif
    output operand_a, operand_b, op, signal_start, signal_mthi, signal_mtlo, write_data,
    input  signal_busy, signal_done, hi_out, lo_out
  );

  modport slave (
`ifdef MULDIV_ABORT_EN
    input  signal_abort,
`endif
    input  operand_a, operand_b, op, signal_start, signal_mthi, signal_mtlo, write_data,
    output signal_busy, signal_done, hi_out, lo_out
  );
endinterface
`default_nettype wire

// File: rtl/mips_mult_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mips_mult_div
// Description : Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO pair.
//               One shift-add or restoring shift-subtract step per cycle,
//               DATA_W steps, then a sign-fix cycle that writes HI/LO.
//               Build macro MULDIV_ABORT_EN adds signal_abort, which drops
//               an operation in progress without touching HI/LO.
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - mips_mult_div_if.slave (operands, op, start, MTHI/
//                       MTLO, write_data, busy, done, hi_out, lo_out)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mult_div #(
  parameter int DATA_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mips_mult_div_if.slave   bus
);
  localparam int                c_CW   = $clog2(DATA_W);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_load;
  logic                w_step;
  logic                w_commit;
  logic                w_abort;

  logic [c_CW-1:0]     r_cnt;
  logic [2*DATA_W-1:0] r_acc;      // {HI-side partial, LO-side partial}
  logic [DATA_W-1:0]   r_mag_b;    // multiplicand / divisor magnitude
  logic [DATA_W-1:0]   r_raw_a;    // unmodified rs, needed for divide-by-zero
  logic                r_is_div;
  logic                r_div0;
  logic                r_neg_q;    // negate product / quotient
  logic                r_neg_r;    // negate remainder
  logic                r_done;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

`ifdef MULDIV_ABORT_EN
  assign w_abort = bus.signal_abort;
`else
  assign w_abort = 1'b0;
`endif

  // ---------------- operand conditioning (signed ops use magnitudes) -------
  logic              w_signed;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;

  assign w_signed = ~bus.op[0];
  assign w_neg_a  = w_signed & bus.operand_a[DATA_W-1];
  assign w_neg_b  = w_signed & bus.operand_b[DATA_W-1];
  assign w_abs_a  = w_neg_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign w_abs_b  = w_neg_b ? (~bus.operand_b + 1'b1) : bus.operand_b;

  // ---------------- FSM ----------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.signal_start) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == c_LAST) w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
        if (!w_abort) w_commit = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- iteration datapath -------------------------------------
  // Multiply: add multiplicand to the upper half when the current multiplier
  // LSB is set, then shift the whole {sum, multiplier} right by one.
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + (r_acc[0] ? {1'b0, r_mag_b} : {(DATA_W+1){1'b0}});
  assign w_mul_acc = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Divide: shift the next dividend bit into the remainder (one extra bit so
  // the shifted remainder cannot overflow), trial-subtract, keep on success.
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;
  logic [2*DATA_W-1:0] w_div_acc;
  assign w_rem_sh  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_mag_b};
  assign w_qbit    = ~w_diff[DATA_W];
  assign w_div_acc = {(w_qbit ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]),
                      r_acc[DATA_W-2:0], w_qbit};

  // ---------------- sign fix / result select -------------------------------
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;
  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*DATA_W-1:DATA_W] + 1'b1) : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_res_hi = w_prod[2*DATA_W-1:DATA_W];
    w_res_lo = w_prod[DATA_W-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        // Divide by zero: raw dividend in HI, sign fix suppressed.
        w_res_hi = r_raw_a;
        w_res_lo = {DATA_W{1'b1}};
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  // ---------------- registers ----------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mag_b  <= '0;
      r_raw_a  <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_commit;
      if (w_load) begin
        r_cnt    <= '0;
        r_acc    <= {{DATA_W{1'b0}}, w_abs_a};
        r_mag_b  <= w_abs_b;
        r_raw_a  <= bus.operand_a;
        r_is_div <= bus.op[1];
        r_div0   <= bus.op[1] & (bus.operand_b == '0);
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end

      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == S_IDLE && !bus.signal_start) begin
        // Moves only land in IDLE; a simultaneous start takes precedence.
        if (bus.signal_mthi) r_hi <= bus.write_data;
        if (bus.signal_mtlo) r_lo <= bus.write_data;
      end
    end
  end

  assign bus.signal_busy = (r_state != S_IDLE);
  assign bus.signal_done = r_done;
  assign bus.hi_out      = r_hi;
  assign bus.lo_out      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_mult_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mips_mult_div
// Description : Self-checking bench for mips_mult_div. Vector table of
//               operations with expected HI/LO, scoreboard queue of expected
//               results, plus hand sequences for in-flight commands, MTHI/
//               MTLO, reset mid-operation and (MULDIV_ABORT_EN) abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mult_div;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_mult_div_if #(.DATA_W(DW)) bus();
  mips_mult_div #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } vec_t;

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference arithmetic, independent of the iterative datapath.
  function automatic exp_t model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = $signed(a);
    sbv = $signed(b);
    e.hi = '0;
    e.lo = '0;
    case (op)
      2'b00: begin sp = 64'(sa) * 64'(sbv); e.hi = sp[63:32]; e.lo = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin e.hi = a; e.lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.hi = '0; e.lo = 32'h8000_0000; end
        else begin e.lo = sa / sbv; e.hi = sa % sbv; end
      end
      default: begin
        if (b == 0) begin e.hi = a; e.lo = '1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  task automatic idle_inputs();
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.op           = 2'b00;
    bus.signal_start = 1'b0;
    bus.signal_mthi  = 1'b0;
    bus.signal_mtlo  = 1'b0;
    bus.write_data   = '0;
`ifdef MULDIV_ABORT_EN
    bus.signal_abort = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for done; returns cycles waited.
  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!bus.signal_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    seen = bus.signal_done;
  endtask

  // Runs one operation: start sampled at edge k, cyc counts edges after k.
  task automatic run_op(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    @(negedge clk);
    bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.signal_start = 1'b1;
    e.hi = hi; e.lo = lo;
    sb_q.push_back(e);
    @(negedge clk);
    bus.signal_start = 1'b0;
    bus.operand_a = '1; bus.operand_b = '1;   // operands must not be re-sampled
    cyc = 0; busy_ok = 1'b1;
    while (!bus.signal_done && cyc < 100) begin
      if (!bus.signal_busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd33);
    check({name, " busy_during"}, 64'(busy_ok), 64'd1);
    check({name, " busy_at_done"}, 64'(bus.signal_busy), 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " hi"}, 64'(bus.hi_out), 64'(e.hi));
      check({name, " lo"}, 64'(bus.lo_out), 64'(e.lo));
    end
    @(negedge clk);
    check({name, " done_pulse"}, 64'(bus.signal_done), 64'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    vec_t v;
    exp_t e;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [1:0]    rop;

    idle_inputs();

    // Spec vectors with hand-derived results.
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1});
    // A few random vectors scored by the reference model.
    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      e   = model(rop, ra, rb);
      vecs.push_back('{rop, ra, rb, e.hi, e.lo});
    end

    do_reset();
    check("reset busy", 64'(bus.signal_busy), 64'd0);
    check("reset done", 64'(bus.signal_done), 64'd0);
    check("reset hi",   64'(bus.hi_out), 64'd0);
    check("reset lo",   64'(bus.lo_out), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v.op, v.a, v.b, v.hi, v.lo);
    end

    // In-flight start/mthi are ignored.
    do_reset();
    @(negedge clk);
    bus.op = 2'b01; bus.operand_a = 32'd5; bus.operand_b = 32'd6; bus.signal_start = 1'b1;
    @(negedge clk);
    bus.signal_start = 1'b0;
    repeat (5) @(negedge clk);
    bus.op = 2'b11; bus.signal_start = 1'b1; bus.signal_mthi = 1'b1; bus.write_data = 32'hAA;
    @(negedge clk);
    bus.signal_start = 1'b0; bus.signal_mthi = 1'b0;
    check("busy_hi_stable", 64'(bus.hi_out), 64'd0);
    wait_done(cyc, seen);
    check("inflight done", 64'(seen), 64'd1);
    check("inflight hi", 64'(bus.hi_out), 64'd0);
    check("inflight lo", 64'(bus.lo_out), 64'd30);
    @(negedge clk);
    check("inflight no_second_op", 64'(bus.signal_busy), 64'd0);

    // MTLO, then MTHI+MTLO together.
    bus.signal_mtlo = 1'b1; bus.write_data = 32'h1234;
    @(negedge clk);
    bus.signal_mtlo = 1'b0;
    check("mtlo lo", 64'(bus.lo_out), 64'h1234);
    check("mtlo hi", 64'(bus.hi_out), 64'd0);
    bus.signal_mthi = 1'b1; bus.signal_mtlo = 1'b1; bus.write_data = 32'h55;
    @(negedge clk);
    bus.signal_mthi = 1'b0; bus.signal_mtlo = 1'b0;
    check("mthilo hi", 64'(bus.hi_out), 64'h55);
    check("mthilo lo", 64'(bus.lo_out), 64'h55);

    // Start together with MTHI in IDLE: start wins.
    bus.op = 2'b01; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
    bus.signal_start = 1'b1; bus.signal_mthi = 1'b1; bus.write_data = 32'h77;
    @(negedge clk);
    bus.signal_start = 1'b0; bus.signal_mthi = 1'b0;
    check("startwins busy", 64'(bus.signal_busy), 64'd1);
    check("startwins hi_held", 64'(bus.hi_out), 64'h55);
    wait_done(cyc, seen);
    check("startwins hi", 64'(bus.hi_out), 64'd0);
    check("startwins lo", 64'(bus.lo_out), 64'd6);

    // Reset mid-operation.
    @(negedge clk);
    bus.op = 2'b01; bus.operand_a = 32'h10; bus.operand_b = 32'h10; bus.signal_start = 1'b1;
    @(negedge clk);
    bus.signal_start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid busy", 64'(bus.signal_busy), 64'd0);
    check("rst_mid hi", 64'(bus.hi_out), 64'd0);
    check("rst_mid lo", 64'(bus.lo_out), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.signal_done) seen = 1'b1; end
    check("rst_mid no_done", 64'(seen), 64'd0);

`ifdef MULDIV_ABORT_EN
    run_op("abort_pre", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.signal_start = 1'b1;
    @(negedge clk);
    bus.signal_start = 1'b0;
    repeat (10) @(negedge clk);
    bus.signal_abort = 1'b1;
    @(negedge clk);
    bus.signal_abort = 1'b0;
    check("abort busy", 64'(bus.signal_busy), 64'd0);
    check("abort hi", 64'(bus.hi_out), 64'd0);
    check("abort lo", 64'(bus.lo_out), 64'd12);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.signal_done) seen = 1'b1; end
    check("abort no_done", 64'(seen), 64'd0);
    // Abort with start in IDLE: start proceeds.
    bus.signal_start = 1'b1; bus.signal_abort = 1'b1;
    @(negedge clk);
    bus.signal_start = 1'b0; bus.signal_abort = 1'b0;
    check("abort_idle busy", 64'(bus.signal_busy), 64'd1);
    wait_done(cyc, seen);
    check("abort_idle hi", 64'(bus.hi_out), 64'd2);
    check("abort_idle lo", 64'(bus.lo_out), 64'd14);
`endif

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
